// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 VGA timing constants shared by the display path
package vga_timing_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam logic VGA_SYNC_POL = 1'b0;

    function automatic int timing_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int VGA_H_TOTAL = timing_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
    localparam int VGA_V_TOTAL = timing_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

endpackage

// File: rtl/vga_sync_delay.sv
// rtl/vga_sync_delay.sv - ce-gated shift register aligning sync/blank flags with ROM-delayed colour
module vga_sync_delay #(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    input  logic [2:0] din,
    output logic [2:0] dout
);

    logic [2:0] stage_q [DEPTH];
    logic [2:0] stage_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i];
        end
        if (ce) begin
            stage_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    // Stages hold "asserted" flags, so zero is the inactive/blank level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= 3'b000;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA timing master: pixel counters, blanking, delayed syncs, line/frame pulses
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   H_FP     = VGA_H_FP,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BP     = VGA_H_BP,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   V_FP     = VGA_V_FP,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BP     = VGA_V_BP,
    parameter logic SYNC_POL = VGA_SYNC_POL,
    parameter int   PIPE_DLY = 1
) (
    input  logic       pixel_clk,
    input  logic       rst_n,
    input  logic       pix_ce,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       video_on,
    output logic       video_on_dly,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL - 1 > 1023 || V_TOTAL - 1 > 1023) begin : g_size_check
        $fatal(1, "vga_sync_gen: H_TOTAL/V_TOTAL exceed 10-bit counters");
    end

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] x_q, x_d, y_q, y_d;
    logic       video_on_q, video_on_d;
    logic       hs_raw_q, hs_raw_d;
    logic       vs_raw_q, vs_raw_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;

    // Flags follow the next-state counts so they describe the x/y presented after this edge.
    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        video_on_d    = video_on_q;
        hs_raw_d      = hs_raw_q;
        vs_raw_d      = vs_raw_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (pix_ce) begin
            if (x_q == H_LAST) begin
                x_d           = 10'd0;
                y_d           = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
                line_start_d  = 1'b1;
                frame_start_d = (y_q == V_LAST);
            end else begin
                x_d = x_q + 10'd1;
            end
            video_on_d = (x_d < H_ACT) && (y_d < V_ACT);
            hs_raw_d   = (x_d >= HS_START) && (x_d < HS_END);
            vs_raw_d   = (y_d >= VS_START) && (y_d < VS_END);
        end
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q           <= 10'd0;
            y_q           <= 10'd0;
            video_on_q    <= 1'b0;
            hs_raw_q      <= 1'b0;
            vs_raw_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            video_on_q    <= video_on_d;
            hs_raw_q      <= hs_raw_d;
            vs_raw_q      <= vs_raw_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    logic [2:0] raw_flags;
    logic [2:0] dly_flags;

    assign raw_flags = {hs_raw_q, vs_raw_q, video_on_q};

    if (PIPE_DLY > 0) begin : g_delay
        vga_sync_delay #(
            .DEPTH (PIPE_DLY)
        ) u_sync_delay (
            .clk   (pixel_clk),
            .rst_n (rst_n),
            .ce    (pix_ce),
            .din   (raw_flags),
            .dout  (dly_flags)
        );
    end else begin : g_bypass
        assign dly_flags = raw_flags;
    end

    assign x            = x_q;
    assign y            = y_q;
    assign video_on     = video_on_q;
    assign video_on_dly = dly_flags[0];
    assign hsync        = dly_flags[2] ? SYNC_POL : ~SYNC_POL;
    assign vsync        = dly_flags[1] ? SYNC_POL : ~SYNC_POL;
    assign line_start   = line_start_q;
    assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - self-checking bench for vga_sync_gen (full-size and reduced-timing builds)
module tb_vga_sync_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       von;
        logic       vond;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pix_ce = 1'b0;

    always #5 clk = ~clk;

    // A: default 640x480 timing, one delay stage. B/C: reduced 16x12 timing so frames fit the run.
    logic [9:0] x_a, y_a, x_b, y_b, x_c, y_c;
    logic von_a, vond_a, hs_a, vs_a, ls_a, fs_a;
    logic von_b, vond_b, hs_b, vs_b, ls_b, fs_b;
    logic von_c, vond_c, hs_c, vs_c, ls_c, fs_c;

    vga_sync_gen u_dut_a (
        .pixel_clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
        .x(x_a), .y(y_a), .video_on(von_a), .video_on_dly(vond_a),
        .hsync(hs_a), .vsync(vs_a), .line_start(ls_a), .frame_start(fs_a)
    );

    vga_sync_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b0), .PIPE_DLY(1)
    ) u_dut_b (
        .pixel_clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
        .x(x_b), .y(y_b), .video_on(von_b), .video_on_dly(vond_b),
        .hsync(hs_b), .vsync(vs_b), .line_start(ls_b), .frame_start(fs_b)
    );

    vga_sync_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b0), .PIPE_DLY(0)
    ) u_dut_c (
        .pixel_clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
        .x(x_c), .y(y_c), .video_on(von_c), .video_on_dly(vond_c),
        .hsync(hs_c), .vsync(vs_c), .line_start(ls_c), .frame_start(fs_c)
    );

    int checks = 0;
    int failures = 0;
    int n = 0;
    bit adv = 1'b0;

    // Expected outputs from the number of pixel advances since reset; flags of advance m
    // describe pixel m, and the reset state (m=0) is blank/inactive.
    function automatic obs_t ref_model(input int cnt, input bit advanced,
                                       input int ha, input int hf, input int hsw, input int hb,
                                       input int va, input int vf, input int vsw, input int vb,
                                       input int dly);
        obs_t r;
        int ht, vt, md, xm, ym;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        r.x = 10'(cnt % ht);
        r.y = 10'((cnt / ht) % vt);
        r.von = (cnt >= 1) && ((cnt % ht) < ha) && (((cnt / ht) % vt) < va);
        md = cnt - dly;
        if (md >= 1) begin
            xm = md % ht;
            ym = (md / ht) % vt;
            r.vond = (xm < ha) && (ym < va);
            r.hs = !((xm >= ha + hf) && (xm < ha + hf + hsw));
            r.vs = !((ym >= va + vf) && (ym < va + vf + vsw));
        end else begin
            r.vond = 1'b0;
            r.hs = 1'b1;
            r.vs = 1'b1;
        end
        r.ls = advanced && (r.x == 10'd0);
        r.fs = advanced && (r.x == 10'd0) && (r.y == 10'd0);
        return r;
    endfunction

    task automatic check_all();
        obs_t got, exp;
        got = {x_a, y_a, von_a, vond_a, hs_a, vs_a, ls_a, fs_a};
        exp = ref_model(n, adv, 640, 16, 96, 48, 480, 10, 2, 33, 1);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL dut_a n=%0d got=%p exp=%p", n, got, exp);
        end
        got = {x_b, y_b, von_b, vond_b, hs_b, vs_b, ls_b, fs_b};
        exp = ref_model(n, adv, 8, 2, 3, 3, 6, 2, 2, 2, 1);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL dut_b n=%0d got=%p exp=%p", n, got, exp);
        end
        got = {x_c, y_c, von_c, vond_c, hs_c, vs_c, ls_c, fs_c};
        exp = ref_model(n, adv, 8, 2, 3, 3, 6, 2, 2, 2, 0);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL dut_c n=%0d got=%p exp=%p", n, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n && pix_ce) begin
            n++;
            adv = 1'b1;
        end else begin
            adv = 1'b0;
        end
        if (!rst_n) n = 0;
        @(negedge clk);
        check_all();
    endtask

    int fall_x_a, rise_x_a, fall_x_c, ls_cnt_a, fs_cnt_b, vs_cnt_b;
    logic prev_hs_a, prev_hs_c;

    initial begin
        fall_x_a = -1; rise_x_a = -1; fall_x_c = -1;
        ls_cnt_a = 0; fs_cnt_b = 0; vs_cnt_b = 0;

        // Reset, then check the state presented before the first advance.
        repeat (3) @(negedge clk);
        check_all();
        rst_n = 1'b1;
        #1;
        check_all();

        // Continuous advance: line wraps, sync windows, reduced-timing frames.
        pix_ce = 1'b1;
        prev_hs_a = hs_a;
        prev_hs_c = hs_c;
        for (int i = 0; i < 1700; i++) begin
            step();
            if (prev_hs_a && !hs_a && fall_x_a < 0) fall_x_a = int'(x_a);
            if (!prev_hs_a && hs_a && rise_x_a < 0) rise_x_a = int'(x_a);
            if (prev_hs_c && !hs_c && fall_x_c < 0) fall_x_c = int'(x_c);
            if (ls_a) ls_cnt_a++;
            if (fs_b) fs_cnt_b++;
            if (n <= 192 && !vs_b) vs_cnt_b++;
            prev_hs_a = hs_a;
            prev_hs_c = hs_c;
        end
        checks++;
        assert (fall_x_a == 657) else begin
            failures++;
            $error("FAIL hsync_fall_x got=%0d exp=657", fall_x_a);
        end
        checks++;
        assert (rise_x_a == 753) else begin
            failures++;
            $error("FAIL hsync_rise_x got=%0d exp=753", rise_x_a);
        end
        checks++;
        assert (fall_x_c == 10) else begin
            failures++;
            $error("FAIL bypass_hsync_fall_x got=%0d exp=10", fall_x_c);
        end
        checks++;
        assert (ls_cnt_a == 2) else begin
            failures++;
            $error("FAIL line_start_count got=%0d exp=2", ls_cnt_a);
        end
        checks++;
        assert (fs_cnt_b == 8) else begin
            failures++;
            $error("FAIL frame_start_count got=%0d exp=8", fs_cnt_b);
        end
        checks++;
        assert (vs_cnt_b == 32) else begin
            failures++;
            $error("FAIL vsync_low_count got=%0d exp=32", vs_cnt_b);
        end

        // One advance in four: everything must hold on the idle clocks.
        for (int i = 0; i < 800; i++) begin
            pix_ce = (i % 4 == 0);
            step();
        end

        // Random enable pattern.
        for (int i = 0; i < 3000; i++) begin
            pix_ce = 1'($urandom_range(0, 1));
            step();
        end

        // Asynchronous reset mid-line, checked before the next edge.
        pix_ce = 1'b1;
        repeat (int'($urandom_range(20, 200))) step();
        #2;
        rst_n = 1'b0;
        n = 0;
        adv = 1'b0;
        #1;
        check_all();
        repeat (2) step();
        rst_n = 1'b1;
        #1;
        check_all();
        for (int i = 0; i < 500; i++) begin
            pix_ce = 1'($urandom_range(0, 3) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
